cnv_row_acc: RTL and testbench
==============================

Name: cnv_row_acc

Overview:
- Parametrised row-level partial-sum accumulator for the convolution PE array.
- Accepts one MAC result per output column, as produced by the kernel-row MAC chain. Adds it into an internal LEN_PSUM-entry psum row buffer across successive kernel/channel passes.
- On the final pass, drains the finished row as a valid/ready stream towards the pooling/output stage.
- Generalises the fixed-width, fixed-length row accumulator with: configurable row length, first/last pass modes, saturation, and back-pressured output.

Parameters:
- MAC_WIDTH, 20, signed width of the incoming MAC result.
- PSUM_WIDTH, 24, signed width of each psum buffer entry and of the output; must be >= MAC_WIDTH.
- LEN_PSUM, 16, number of psum entries (maximum output columns per row).
- ADDR_WIDTH, clog2(LEN_PSUM), width of column counters and cfg_len.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- row_sta  in  1  single-cycle pulse; starts a pass; cfg_* sampled on this cycle
- cfg_len  in  ADDR_WIDTH  active columns this pass; 0 means LEN_PSUM
- cfg_first  in  1  pass overwrites the buffer instead of accumulating
- cfg_last  in  1  pass is followed by a drain of the row
- mac_vld  in  1  mac_val valid
- mac_rdy  out  1  block accepts mac_val
- mac_val  in  MAC_WIDTH  signed MAC result for the current column
- out_vld  out  1  out_psum valid
- out_rdy  in  1  downstream accepts out_psum
- out_psum  out  PSUM_WIDTH  signed finished psum for the current drain column
- out_last  out  1  high with the final drained column
- busy  out  1  state != IDLE
- row_done  out  1  single-cycle pulse when a pass (and its drain, if any) completes

Behaviour:
- Reset values: every output 0; all buffer entries 0; column counter 0; state IDLE; latched cfg 0.
- States:
  - IDLE: on row_sta, latch len, first and last; set col=0; go to ACC.
  - ACC: mac_rdy=1. A transfer is mac_vld&mac_rdy; it updates buf[col] on the next clock edge.
    - If first: buf[col] <= sign-extended mac_val.
    - Otherwise: buf[col] <= sat(buf[col] + mac_val).
    - col increments on each transfer.
    - On the transfer at col==len-1: col<=0. If last, go to DRAIN; otherwise pulse row_done and go to IDLE.
  - DRAIN: out_vld=1, out_psum=buf[col], out_last=(col==len-1). On out_vld&out_rdy, col increments. On the final handshake, pulse row_done the following cycle and go to IDLE.
- Output timing and stalls:
  - out_psum is a registered-buffer read and is stable while out_rdy is low.
  - An out_rdy stall holds col, out_psum and out_last unchanged.
- Arithmetic:
  - Signed two's-complement addition at PSUM_WIDTH+1 bits.
  - sat clamps to [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1].
- Boundary conditions:
  - row_sta outside IDLE is ignored; no cfg re-latch.
  - mac_vld in IDLE or DRAIN is ignored, and mac_rdy=0 there.
  - Entries with index >= len are untouched by a pass and are never drained.
  - cfg_len=0 behaves as LEN_PSUM.
  - cfg_first=1 with cfg_last=1 is a single-pass row: write, then drain.
  - A row_sta in the same cycle as the row_done pulse is ignored; row_sta is accepted only while the state is IDLE.
  - Reset asserted mid-pass or mid-drain returns to IDLE immediately, clears the buffer, and drops out_vld. No row_done is produced.
- Throughput and latency:
  - ACC: one column per cycle with mac_vld held high; the pass takes len cycles.
  - DRAIN: one column per cycle with out_rdy held high.
  - The first out_vld appears the cycle after the last ACC transfer.

Optional Feature:
- Macro CNVROW_RELU_EN.
- Defined: out_psum is max(buf[col],0) during DRAIN; the buffer contents are unchanged.
- Undefined: out_psum = buf[col] unmodified.

Test Plan:
- Single pass: row_sta with cfg_len=4, first=1, last=1; mac_val 1,2,3,4 back-to-back; out_rdy=1 -> out_psum 1,2,3,4 on consecutive cycles, out_last on 4, row_done one cycle later, busy low afterwards.
- Three-pass accumulate: len=3; pass values (10,20,30), (1,1,1), (-5,0,5) with first only on the first pass and last only on the third -> drain outputs 6,21,36. row_done pulses after each pass.
- Saturation (PSUM_WIDTH=24): first pass 8388000 (fits MAC_WIDTH=24 test config), then +1000 -> drained 8388607. Negative case: -8388000 then -1000 -> -8388608.
- Back-pressure: drain of 3 entries with out_rdy low for 5 cycles on column 1 -> out_psum and out_last held stable; exactly 3 handshakes; mac_rdy stays 0 throughout.
- Edge config: cfg_len=0 (LEN_PSUM=16), first=1, last=1, values 0..15 -> 16 outputs, out_last on 15. Then reset mid-drain at column 7 -> out_vld=0, busy=0, no row_done; a fresh non-first pass accumulates onto zeros.
- RELU (CNVROW_RELU_EN defined): single pass -3,4 -> outputs 0,4. Without the macro -> -3,4.

Source files
------------

// File: rtl/cnv_row_acc_if.sv
// Stream bundle for cnv_row_acc: MAC results in (mac_*) and finished psums out (out_*).
// The slave modport is the accumulator's view; master is the MAC chain / pooling side.
interface cnv_row_acc_if #(
    parameter int MAC_WIDTH  = 20,
    parameter int PSUM_WIDTH = 24
) ();
    logic                         mac_vld;
    logic                         mac_rdy;
    logic signed [MAC_WIDTH-1:0]  mac_val;
    logic                         out_vld;
    logic                         out_rdy;
    logic signed [PSUM_WIDTH-1:0] out_psum;
    logic                         out_last;

    modport slave (
        input  mac_vld,
        input  mac_val,
        output mac_rdy,
        output out_vld,
        input  out_rdy,
        output out_psum,
        output out_last
    );

    modport master (
        output mac_vld,
        output mac_val,
        input  mac_rdy,
        input  out_vld,
        output out_rdy,
        input  out_psum,
        input  out_last
    );
endinterface

// File: rtl/cnv_row_acc.sv
// Row-level partial-sum accumulator: saturating accumulate of MAC results over passes, then drains the row.
// Optional macro CNVROW_RELU_EN clamps drained values at zero (buffer contents stay signed).
module cnv_row_acc #(
    parameter int MAC_WIDTH  = 20,
    parameter int PSUM_WIDTH = 24,
    parameter int LEN_PSUM   = 16,
    parameter int ADDR_WIDTH = $clog2(LEN_PSUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_row_sta,
    input  logic [ADDR_WIDTH-1:0] i_cfg_len,
    input  logic                  i_cfg_first,
    input  logic                  i_cfg_last,
    cnv_row_acc_if.slave          if_s,
    output logic                  o_busy,
    output logic                  o_row_done
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [ADDR_WIDTH-1:0]        r_col;
    logic [ADDR_WIDTH-1:0]        r_len;
    logic                         r_first;
    logic                         r_last;
    logic signed [PSUM_WIDTH-1:0] r_buf [LEN_PSUM];

    logic                         w_mac_rdy;
    logic                         w_out_vld;
    logic                         w_busy;
    logic                         w_row_done;
    logic                         w_start;
    logic                         w_acc_xfer;
    logic                         w_out_xfer;
    logic                         w_col_end;
    logic [ADDR_WIDTH-1:0]        w_last_idx;
    logic signed [PSUM_WIDTH-1:0] w_rd;

    function automatic logic signed [PSUM_WIDTH-1:0] sat_add(
        input logic signed [PSUM_WIDTH-1:0] a,
        input logic signed [MAC_WIDTH-1:0]  b
    );
        logic signed [PSUM_WIDTH:0] s;
        s = (PSUM_WIDTH+1)'(a) + (PSUM_WIDTH+1)'(b);
        if (s[PSUM_WIDTH] != s[PSUM_WIDTH-1])
            sat_add = s[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                    : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
        else
            sat_add = s[PSUM_WIDTH-1:0];
    endfunction

`ifdef CNVROW_RELU_EN
    function automatic logic signed [PSUM_WIDTH-1:0] relu(input logic signed [PSUM_WIDTH-1:0] x);
        relu = x[PSUM_WIDTH-1] ? '0 : x;
    endfunction
`endif

    // cfg_len of zero selects the full buffer length
    assign w_last_idx = (r_len == '0) ? ADDR_WIDTH'(LEN_PSUM - 1) : r_len - ADDR_WIDTH'(1);
    assign w_col_end  = (r_col == w_last_idx);
    assign w_start    = (r_state == S_IDLE) && i_row_sta;
    assign w_acc_xfer = w_mac_rdy && if_s.mac_vld;
    assign w_out_xfer = w_out_vld && if_s.out_rdy;
    assign w_rd       = r_buf[r_col];

    always_comb begin
        w_state_nxt = r_state;
        w_mac_rdy   = 1'b0;
        w_out_vld   = 1'b0;
        w_busy      = 1'b1;
        w_row_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_row_sta) w_state_nxt = S_ACC;
            end
            S_ACC: begin
                w_mac_rdy = 1'b1;
                if (if_s.mac_vld && w_col_end) w_state_nxt = r_last ? S_DRAIN : S_DONE;
            end
            S_DRAIN: begin
                w_out_vld = 1'b1;
                if (if_s.out_rdy && w_col_end) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // holding a non-IDLE state here makes a row_sta coincident with row_done ignored
                w_row_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_len   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_start) begin
            r_col   <= '0;
            r_len   <= i_cfg_len;
            r_first <= i_cfg_first;
            r_last  <= i_cfg_last;
        end else if (w_acc_xfer || w_out_xfer) begin
            r_col <= w_col_end ? '0 : r_col + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN_PSUM; i++) r_buf[i] <= '0;
        end else if (w_acc_xfer) begin
            r_buf[r_col] <= r_first ? PSUM_WIDTH'(if_s.mac_val) : sat_add(r_buf[r_col], if_s.mac_val);
        end
    end

    assign if_s.mac_rdy  = w_mac_rdy;
    assign if_s.out_vld  = w_out_vld;
    assign if_s.out_last = w_out_vld && w_col_end;
`ifdef CNVROW_RELU_EN
    assign if_s.out_psum = w_out_vld ? relu(w_rd) : '0;
`else
    assign if_s.out_psum = w_out_vld ? w_rd : '0;
`endif
    assign o_busy        = w_busy;
    assign o_row_done    = w_row_done;

endmodule

// File: tb/tb_cnv_row_acc.sv
// Directed bench for cnv_row_acc: table of accumulate/drain passes plus back-pressure,
// full-length and mid-drain reset sequences.
module tb_cnv_row_acc;
    localparam int MW  = 24;
    localparam int PW  = 24;
    localparam int LEN = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          row_sta;
    logic [AW-1:0] cfg_len;
    logic          cfg_first;
    logic          cfg_last;
    logic          busy;
    logic          row_done;

    always #5 clk = ~clk;

    cnv_row_acc_if #(.MAC_WIDTH(MW), .PSUM_WIDTH(PW)) bus ();

    cnv_row_acc #(.MAC_WIDTH(MW), .PSUM_WIDTH(PW), .LEN_PSUM(LEN), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_row_sta  (row_sta),
        .i_cfg_len  (cfg_len),
        .i_cfg_first(cfg_first),
        .i_cfg_last (cfg_last),
        .if_s       (bus.slave),
        .o_busy     (busy),
        .o_row_done (row_done)
    );

    typedef struct {
        int len;
        bit first;
        bit last;
        int v[4];
        int e[4];
    } vec_t;

    vec_t tbl[10];
    int   pv[LEN];
    int   pe[LEN];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int relu_ref(input int x);
`ifdef CNVROW_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    // Starts a pass and streams pv[0..n-1] back-to-back; returns at the negedge after the last transfer.
    task automatic feed(input int len, input bit first, input bit last);
        int n;
        n = (len == 0) ? LEN : len;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        row_sta   = 1'b1;
        cfg_len   = AW'(len);
        cfg_first = first;
        cfg_last  = last;
        @(negedge clk);
        row_sta   = 1'b0;
        cfg_len   = '0;
        cfg_first = 1'b0;
        cfg_last  = 1'b0;
        bus.mac_vld = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.mac_val = MW'(pv[i]);
            if (i == 0) chk("acc_rdy", bus.mac_rdy, 1);
            @(negedge clk);
        end
        bus.mac_vld = 1'b0;
        bus.mac_val = '0;
    endtask

    task automatic finish_row();
        chk("row_done_pulse", row_done, 1);
        chk("done_out_vld", bus.out_vld, 0);
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_row_done", row_done, 0);
    endtask

    task automatic run_pass(input int len, input bit first, input bit last);
        int n;
        n = (len == 0) ? LEN : len;
        feed(len, first, last);
        if (last) begin
            for (int j = 0; j < n; j++) begin
                chk("drain_vld", bus.out_vld, 1);
                chk("drain_mac_rdy", bus.mac_rdy, 0);
                chk("drain_psum", bus.out_psum, relu_ref(pe[j]));
                chk("drain_last", bus.out_last, int'(j == n - 1));
                @(negedge clk);
            end
        end
        finish_row();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int hs;
        row_sta     = 1'b0;
        cfg_len     = '0;
        cfg_first   = 1'b0;
        cfg_last    = 1'b0;
        bus.mac_vld = 1'b0;
        bus.mac_val = '0;
        bus.out_rdy = 1'b1;

        tbl[0] = '{4, 1'b1, 1'b1, '{1, 2, 3, 4},       '{1, 2, 3, 4}};
        tbl[1] = '{3, 1'b1, 1'b0, '{10, 20, 30, 0},    '{0, 0, 0, 0}};
        tbl[2] = '{3, 1'b0, 1'b0, '{1, 1, 1, 0},       '{0, 0, 0, 0}};
        tbl[3] = '{3, 1'b0, 1'b1, '{-5, 0, 5, 0},      '{6, 21, 36, 0}};
        tbl[4] = '{4, 1'b0, 1'b1, '{0, 0, 0, 0},       '{6, 21, 36, 4}};
        tbl[5] = '{1, 1'b1, 1'b0, '{8388000, 0, 0, 0}, '{0, 0, 0, 0}};
        tbl[6] = '{1, 1'b0, 1'b1, '{1000, 0, 0, 0},    '{8388607, 0, 0, 0}};
        tbl[7] = '{1, 1'b1, 1'b0, '{-8388000, 0, 0, 0},'{0, 0, 0, 0}};
        tbl[8] = '{1, 1'b0, 1'b1, '{-1000, 0, 0, 0},   '{-8388608, 0, 0, 0}};
        tbl[9] = '{2, 1'b1, 1'b1, '{-3, 4, 0, 0},      '{-3, 4, 0, 0}};

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_row_done", row_done, 0);
        chk("rst_mac_rdy", bus.mac_rdy, 0);
        chk("rst_out_vld", bus.out_vld, 0);
        chk("rst_out_psum", bus.out_psum, 0);
        chk("rst_out_last", bus.out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 4; i++) begin
                pv[i] = tbl[k].v[i];
                pe[i] = tbl[k].e[i];
            end
            run_pass(tbl[k].len, tbl[k].first, tbl[k].last);
        end

        // Back-pressure on column 1, with stray row_sta/mac_vld that must be ignored
        pv[0] = 7; pv[1] = 8; pv[2] = 9;
        feed(3, 1'b1, 1'b1);
        hs = 0;
        chk("bp_psum0", bus.out_psum, 7);
        if (bus.out_vld && bus.out_rdy) hs++;
        @(negedge clk);
        bus.out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_vld", bus.out_vld, 1);
            chk("bp_hold_psum", bus.out_psum, 8);
            chk("bp_hold_last", bus.out_last, 0);
            chk("bp_hold_mac_rdy", bus.mac_rdy, 0);
            row_sta     = 1'b1;
            cfg_len     = AW'(2);
            cfg_first   = 1'b1;
            bus.mac_vld = 1'b1;
            bus.mac_val = MW'(99);
            if (bus.out_vld && bus.out_rdy) hs++;
            @(negedge clk);
        end
        row_sta     = 1'b0;
        cfg_len     = '0;
        cfg_first   = 1'b0;
        bus.mac_vld = 1'b0;
        bus.mac_val = '0;
        bus.out_rdy = 1'b1;
        chk("bp_psum1", bus.out_psum, 8);
        chk("bp_last1", bus.out_last, 0);
        if (bus.out_vld && bus.out_rdy) hs++;
        @(negedge clk);
        chk("bp_psum2", bus.out_psum, 9);
        chk("bp_last2", bus.out_last, 1);
        if (bus.out_vld && bus.out_rdy) hs++;
        @(negedge clk);
        chk("bp_handshakes", hs, 3);
        finish_row();

        // cfg_len=0 selects all 16 columns
        for (int i = 0; i < LEN; i++) begin
            pv[i] = i;
            pe[i] = i;
        end
        run_pass(0, 1'b1, 1'b1);

        // Reset in the middle of a full-length drain
        for (int i = 0; i < LEN; i++) pv[i] = 100 + i;
        feed(0, 1'b1, 1'b1);
        for (int j = 0; j < 7; j++) begin
            chk("rd_psum", bus.out_psum, 100 + j);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("rd_out_vld", bus.out_vld, 0);
        chk("rd_busy", busy, 0);
        chk("rd_out_psum", bus.out_psum, 0);
        @(negedge clk);
        chk("rd_row_done", row_done, 0);
        chk("rd_busy_hold", busy, 0);
        rst_n = 1'b1;

        // Non-first pass after reset accumulates onto a cleared buffer
        pv[0] = 5; pv[1] = 6; pv[2] = -2;
        pe[0] = 5; pe[1] = 6; pe[2] = -2;
        run_pass(3, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
